// File: rtl/bp_nbf_uart_tx.sv
// bp_nbf_uart_tx: shifts NBF packets out as 8-bit UART frames, opcode byte first, line idle-high.
// Optional macro BP_NBF_UART_TX_GAP_EN inserts a 10-bit-time idle gap after each packet.
module bp_nbf_uart_tx
  #(parameter int nbf_addr_width_p   = 40,
    parameter int nbf_data_width_p   = 64,
    parameter int uart_clk_per_bit_p = 10416,
    parameter int uart_data_bits_p   = 8,
    parameter int uart_parity_bit_p  = 0,
    parameter int uart_parity_odd_p  = 0,
    parameter int uart_stop_bits_p   = 1,
    localparam int nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p,
    localparam int nbf_bytes_lp = (nbf_width_lp + 7) / 8)
  (input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic [nbf_width_lp-1:0] nbf_i,
   input  logic                    nbf_v_i,
   output logic                    nbf_ready_and_o,
   output logic                    tx_o,
   output logic                    busy_o);

  localparam int clk_cnt_w_lp  = (uart_clk_per_bit_p > 1) ? $clog2(uart_clk_per_bit_p) : 1;
  localparam int byte_cnt_w_lp = $clog2(nbf_bytes_lp + 1);
  localparam int shift_w_lp    = nbf_bytes_lp * 8;

  if (uart_data_bits_p != 8) begin : g_bad_data_bits
    $error("bp_nbf_uart_tx: uart_data_bits_p must be 8");
  end
  if (uart_stop_bits_p < 1 || uart_stop_bits_p > 2) begin : g_bad_stop_bits
    $error("bp_nbf_uart_tx: uart_stop_bits_p must be 1 or 2");
  end
  if (uart_clk_per_bit_p < 2) begin : g_bad_clk_per_bit
    $error("bp_nbf_uart_tx: uart_clk_per_bit_p must be at least 2");
  end

  typedef enum logic [2:0] {
    e_idle,
    e_start,
    e_data,
    e_parity,
    e_stop
`ifdef BP_NBF_UART_TX_GAP_EN
    , e_gap
`endif
  } state_e;

  function automatic logic f_parity(input logic [7:0] b);
    return (uart_parity_odd_p != 0) ? ~^b : ^b;
  endfunction

  state_e                    r_state, w_state_nxt;
  logic [clk_cnt_w_lp-1:0]   r_clk_cnt, w_clk_cnt_nxt;
  logic [3:0]                r_bit_cnt, w_bit_cnt_nxt;
  logic [byte_cnt_w_lp-1:0]  r_byte_cnt, w_byte_cnt_nxt;
  logic [shift_w_lp-1:0]     r_shift;
  logic                      w_bit_end, w_last_stop, w_hs, w_byte_done, w_tx;

  assign w_bit_end   = (r_clk_cnt == clk_cnt_w_lp'(uart_clk_per_bit_p - 1));
  assign w_last_stop = (r_bit_cnt == 4'(uart_stop_bits_p - 1));
  assign w_hs        = (r_state == e_idle) & nbf_v_i;
  assign w_byte_done = (r_state == e_stop) & w_bit_end & w_last_stop;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= e_idle;
      r_clk_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_cnt  <= w_clk_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // Current byte always sits in r_shift[7:0]; it advances by one byte per completed frame.
  always_ff @(posedge clk_i) begin
    if (w_hs)
      r_shift <= shift_w_lp'(nbf_i);
    else if (w_byte_done)
      r_shift <= r_shift >> 8;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clk_cnt_nxt  = w_bit_end ? '0 : r_clk_cnt + 1'b1;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    case (r_state)
      e_idle: begin
        w_clk_cnt_nxt = '0;
        if (nbf_v_i) begin
          w_state_nxt    = e_start;
          w_byte_cnt_nxt = byte_cnt_w_lp'(nbf_bytes_lp);
        end
      end
      e_start: begin
        if (w_bit_end) w_state_nxt = e_data;
      end
      e_data: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 4'd7) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (uart_parity_bit_p != 0) ? e_parity : e_stop;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      e_parity: begin
        if (w_bit_end) w_state_nxt = e_stop;
      end
      e_stop: begin
        if (w_bit_end) begin
          if (w_last_stop) begin
            w_bit_cnt_nxt  = '0;
            w_byte_cnt_nxt = r_byte_cnt - 1'b1;
            if (r_byte_cnt == byte_cnt_w_lp'(1))
`ifdef BP_NBF_UART_TX_GAP_EN
              w_state_nxt = e_gap;
`else
              w_state_nxt = e_idle;
`endif
            else
              w_state_nxt = e_start;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
`ifdef BP_NBF_UART_TX_GAP_EN
      // Gap reuses the bit counter to time ten idle bit periods.
      e_gap: begin
        if (w_bit_end) begin
          if (r_bit_cnt == 4'd9) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = e_idle;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
`endif
      default: begin
        w_state_nxt   = e_idle;
        w_clk_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      e_start:  w_tx = 1'b0;
      e_data:   w_tx = r_shift[r_bit_cnt[2:0]];
      e_parity: w_tx = f_parity(r_shift[7:0]);
      default:  w_tx = 1'b1;
    endcase
  end

  assign tx_o            = w_tx;
  assign nbf_ready_and_o = (r_state == e_idle);
  assign busy_o          = (r_state != e_idle);

endmodule

// File: tb/tb_bp_nbf_uart_tx.sv
// Bench for bp_nbf_uart_tx: three instances (no parity/1 stop, even/2 stop, odd/1 stop)
// checked every cycle against a queue-of-line-levels model, plus literal timing and decode checks.
module tb_bp_nbf_uart_tx;
  localparam int CPB  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int PW   = 8 + AW + DW;
  localparam int NB   = 9;
  localparam int HMAX = 32768;
`ifdef BP_NBF_UART_TX_GAP_EN
  localparam int READY_AT = 401;
`else
  localparam int READY_AT = 361;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] nbf = '0;
  logic [2:0]    v = '0;
  logic [2:0]    tx_w, rdy_w, busy_w;

  always #5 clk = ~clk;

  bp_nbf_uart_tx #(.nbf_addr_width_p(AW), .nbf_data_width_p(DW), .uart_clk_per_bit_p(CPB),
    .uart_data_bits_p(8), .uart_parity_bit_p(0), .uart_parity_odd_p(0), .uart_stop_bits_p(1))
    dut0 (.clk_i(clk), .reset_i(rst), .nbf_i(nbf), .nbf_v_i(v[0]),
          .nbf_ready_and_o(rdy_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]));
  bp_nbf_uart_tx #(.nbf_addr_width_p(AW), .nbf_data_width_p(DW), .uart_clk_per_bit_p(CPB),
    .uart_data_bits_p(8), .uart_parity_bit_p(1), .uart_parity_odd_p(0), .uart_stop_bits_p(2))
    dut1 (.clk_i(clk), .reset_i(rst), .nbf_i(nbf), .nbf_v_i(v[1]),
          .nbf_ready_and_o(rdy_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]));
  bp_nbf_uart_tx #(.nbf_addr_width_p(AW), .nbf_data_width_p(DW), .uart_clk_per_bit_p(CPB),
    .uart_data_bits_p(8), .uart_parity_bit_p(1), .uart_parity_odd_p(1), .uart_stop_bits_p(1))
    dut2 (.clk_i(clk), .reset_i(rst), .nbf_i(nbf), .nbf_v_i(v[2]),
          .nbf_ready_and_o(rdy_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cnt [3] = '{0, 0, 0};
  int hs_last[3] = '{0, 0, 0};
  logic rst_prev = 1'b1;
  logic armed = 1'b0;
  logic [2:0] htx [0:HMAX-1];
  logic [2:0] hrdy[0:HMAX-1];

  // Model: one {busy, tx} entry per future cycle; empty queue means idle and ready.
  logic [1:0] q0[$], q1[$], q2[$];
  logic [7:0] dec_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_bit(input string nm, input int k, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%b want=%b", nm, k, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int k, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0d want=%0d", nm, k, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout cyc=%0d got=waiting want=done", nm, cyc);
  endtask

  function automatic int par_en(input int k);   return (k != 0) ? 1 : 0; endfunction
  function automatic int par_odd(input int k);  return (k == 2) ? 1 : 0; endfunction
  function automatic int stops(input int k);    return (k == 1) ? 2 : 1; endfunction

  task automatic q_push(input int k, input logic [1:0] it);
    case (k)
      0: q0.push_back(it);
      1: q1.push_back(it);
      default: q2.push_back(it);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [1:0] q_front(input int k);
    if (q_size(k) == 0) return 2'b01;
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    if (q_size(k) > 0) begin
      case (k)
        0: void'(q0.pop_front());
        1: void'(q1.pop_front());
        default: void'(q2.pop_front());
      endcase
    end
  endtask

  task automatic push_packet(input int k, input logic [PW-1:0] pkt);
    logic [7:0] by;
    logic       pb;
    for (int b = 0; b < NB; b++) begin
      by = pkt[8*b +: 8];
      repeat (CPB) q_push(k, 2'b10);
      for (int i = 0; i < 8; i++) repeat (CPB) q_push(k, {1'b1, by[i]});
      if (par_en(k) != 0) begin
        pb = (par_odd(k) != 0) ? ~^by : ^by;
        repeat (CPB) q_push(k, {1'b1, pb});
      end
      repeat (stops(k) * CPB) q_push(k, 2'b11);
    end
`ifdef BP_NBF_UART_TX_GAP_EN
    repeat (10 * CPB) q_push(k, 2'b11);
`endif
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_prev) begin
      q0.delete(); q1.delete(); q2.delete();
      armed = 1'b1;
    end
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        e = q_front(k);
        check_bit("tx", k, tx_w[k], e[0]);
        check_bit("ready", k, rdy_w[k], ~e[1]);
        check_bit("busy", k, busy_w[k], e[1]);
        if (cyc < HMAX) begin
          htx[cyc][k]  = tx_w[k];
          hrdy[cyc][k] = rdy_w[k];
        end
        q_pop(k);
        if (!rst && v[k] && !e[1]) begin
          push_packet(k, nbf);
          hs_cnt[k]++;
          hs_last[k] = cyc;
        end
      end
    end
    rst_prev = rst;
  end

  // Mid-bit line decoder for dut0 (no parity, one stop bit).
  int dpos = -1;
  logic [7:0] dbyte = '0;
  always @(negedge clk) begin
    if (rst) dpos = -1;
    else if (dpos < 0) begin
      if (tx_w[0] === 1'b0) dpos = 0;
    end else begin
      dpos++;
      if (dpos >= 5 && dpos <= 33 && (dpos % CPB) == 1) dbyte[(dpos - 5) / CPB] = tx_w[0];
      if (dpos == 37) begin
        if (tx_w[0] === 1'b1) dec_q.push_back(dbyte);
        dpos = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] pkt, input logic [2:0] mask);
    int c0[3];
    int budget;
    for (int k = 0; k < 3; k++) c0[k] = hs_cnt[k];
    nbf = pkt;
    v = mask;
    budget = 0;
    while (v != 3'b000 && budget < 3000) begin
      tick();
      budget++;
      for (int k = 0; k < 3; k++) if (v[k] && hs_cnt[k] != c0[k]) v[k] = 1'b0;
    end
    if (v != 3'b000) begin
      timeout("send");
      v = '0;
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((q_size(0) + q_size(1) + q_size(2)) != 0 && budget < 5000) begin
      tick();
      budget++;
    end
    if (budget >= 5000) timeout("idle");
    tick();
  endtask

  task automatic check_decode(input string nm, input logic [PW-1:0] pa, input logic [PW-1:0] pb, input int npk);
    check_int({nm, "_count"}, 0, dec_q.size(), npk * NB);
    for (int i = 0; i < npk * NB && i < dec_q.size(); i++)
      check_int({nm, "_byte"}, 0, int'(dec_q[i]), (i < NB) ? int'(pa[8*i +: 8]) : int'(pb[8*(i-NB) +: 8]));
  endtask

  logic [7:0] exp1[NB] = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    logic [PW-1:0] p1, pa, pb, pp, pr;
    int t, t1, t2, c, budget;
    p1 = {32'hDEAD_BEEF, 32'h0000_1000, 8'h02};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    for (int i = 1; i <= 4; i++) begin
      check_bit("rst_tx", 0, htx[i][0], 1'b1);
      check_bit("rst_ready", 0, hrdy[i][0], 1'b1);
    end

    // Single packet with known line bytes.
    dec_q.delete();
    send(p1, 3'b001);
    t = hs_last[0];
    wait_idle();
    tick();
    check_bit("start_at_T1", 0, htx[t+1][0], 1'b0);
    check_bit("idle_before_T1", 0, htx[t][0], 1'b1);
    check_bit("last_stop", 0, htx[t+360][0], 1'b1);
    check_bit("busy_at_end", 0, hrdy[t+READY_AT-1][0], 1'b0);
    check_bit("ready_rise", 0, hrdy[t+READY_AT][0], 1'b1);
`ifdef BP_NBF_UART_TX_GAP_EN
    check_bit("gap_first", 0, htx[t+361][0], 1'b1);
    check_bit("gap_last", 0, htx[t+400][0], 1'b1);
`endif
    check_int("dec1_count", 0, dec_q.size(), NB);
    for (int i = 0; i < NB && i < dec_q.size(); i++) check_int("dec1_byte", 0, int'(dec_q[i]), int'(exp1[i]));

    // Parity on byte 0x07: even sends 1, odd sends 0; dut1 holds its two stop bits 8 cycles.
    pp = {$urandom(), $urandom(), 8'h07};
    send(pp, 3'b110);
    t1 = hs_last[1];
    t2 = hs_last[2];
    wait_idle();
    tick();
    check_int("par_hs_same", 1, t1, t2);
    check_bit("even_parity", 1, htx[t1+38][1], 1'b1);
    check_bit("odd_parity", 2, htx[t2+38][2], 1'b0);
    check_bit("stop2_first", 1, htx[t1+41][1], 1'b1);
    check_bit("stop2_last", 1, htx[t1+48][1], 1'b1);
    check_bit("stop2_next_start", 1, htx[t1+49][1], 1'b0);
    check_bit("stop1_last", 2, htx[t2+44][2], 1'b1);
    check_bit("stop1_next_start", 2, htx[t2+45][2], 1'b0);

    // Back-to-back with valid held high.
    pa = {$urandom(), $urandom(), 8'($urandom())};
    pb = {$urandom(), $urandom(), 8'($urandom())};
    dec_q.delete();
    c = hs_cnt[0];
    nbf = pa;
    v = 3'b001;
    budget = 0;
    while (hs_cnt[0] == c && budget < 3000) begin tick(); budget++; end
    t1 = hs_last[0];
    nbf = pb;
    while (hs_cnt[0] < c + 2 && budget < 3000) begin tick(); budget++; end
    t2 = hs_last[0];
    v = '0;
    if (budget >= 3000) timeout("b2b");
    wait_idle();
    tick();
    check_int("b2b_spacing", 0, t2 - t1, READY_AT);
    check_bit("b2b_stop", 0, htx[t1+READY_AT-1][0], 1'b1);
    check_bit("b2b_idle", 0, htx[t1+READY_AT][0], 1'b1);
    check_bit("b2b_start", 0, htx[t1+READY_AT+1][0], 1'b0);
    check_decode("dec_b2b", pa, pb, 2);

    // Reset in byte 1's data phase, then a clean packet.
    send(p1, 3'b001);
    t = hs_last[0];
    while (cyc < t + 50) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_bit("mid_rst_tx", 0, htx[t+51][0], 1'b1);
    check_bit("mid_rst_ready", 0, hrdy[t+51][0], 1'b1);
    dec_q.delete();
    pr = {$urandom(), $urandom(), 8'($urandom())};
    send(pr, 3'b001);
    wait_idle();
    check_decode("dec_after_rst", pr, pr, 1);

    // Randomized traffic, with input changes while busy and one random reset.
    for (int r = 0; r < 20; r++) begin
      pr = {$urandom(), $urandom(), 8'($urandom())};
      send(pr, 3'($urandom_range(1, 7)));
      repeat ($urandom_range(0, 300)) begin
        nbf = {$urandom(), $urandom(), 8'($urandom())};
        tick();
      end
      if (r == 10) begin
        repeat ($urandom_range(1, 200)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    wait_idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_nbf_uart_tx.md
# bp_nbf_uart_tx

Serializes NBF packets into the UART byte stream that the FPGA host consumes on its `rx_i` pin. It is the host-PC end of the NBF-over-UART link, built as a synthesizable block. It drives FPGA-host bring-up benches and on-board self-load images. Each accepted NBF packet is split into bytes and shifted out as standard UART frames, with the line idle-high between packets.

## Interface
Parameters:
- `nbf_addr_width_p`, default `paddr_width_p` (40): NBF address field width.
- `nbf_data_width_p`, default `dword_width_gp` (64): NBF data field width.
- `nbf_width_lp`, localparam, 8 + addr + data: packet width; opcode in bits [7:0], then addr, then data.
- `nbf_bytes_lp`, localparam, ceil(`nbf_width_lp`/8): bytes per packet; upper pad bits are zero.
- `uart_clk_per_bit_p`, default 10416: clock cycles per bit (100 MHz / 9600 baud); must be ≥2.
- `uart_data_bits_p`, default 8: data bits per frame; only 8 is legal, checked by an elaboration assertion.
- `uart_parity_bit_p`, default 0: 1 appends a parity bit.
- `uart_parity_odd_p`, default 0: 0 selects even parity, 1 selects odd.
- `uart_stop_bits_p`, default 1: stop bits per frame, 1 or 2.

Ports:
- `clk_i`, input, 1: clock.
- `reset_i`, input, 1: synchronous, active-high reset.
- `nbf_i`, input, `nbf_width_lp`: packet to send.
- `nbf_v_i`, input, 1: packet valid.
- `nbf_ready_and_o`, output, 1: ready; a handshake occurs on `nbf_v_i & nbf_ready_and_o`.
- `tx_o`, output, 1: UART line to the FPGA host `rx_i`.
- `busy_o`, output, 1: high while a packet is in flight.

## Operation
- On handshake, latch `nbf_i` into a shift register and load the byte counter with `nbf_bytes_lp`.
- Byte order is byte 0 (opcode) first, then the remaining bytes in ascending order. Address and data therefore go out little-endian.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits (1).
- Parity bit: even parity sends `^byte`; odd parity sends `~^byte`.
- State machine:
  - `e_idle` → `e_start` on handshake.
  - `e_start` → `e_data`.
  - `e_data` → `e_parity` after bit 7 if parity is enabled, otherwise → `e_stop`.
  - `e_parity` → `e_stop`.
  - `e_stop` → `e_start` after the last stop bit if bytes remain. Otherwise → `e_idle`, or → `e_gap` when the gap macro is defined.
  - `e_gap` → `e_idle`.
- A clock counter of width `BSG_SAFE_CLOG2(uart_clk_per_bit_p)` times each bit. A 4-bit bit counter and a byte counter track frame and packet position.
- `nbf_ready_and_o` is high only in `e_idle`. `busy_o` is its complement.
- `nbf_i` is ignored outside the handshake cycle. Changes to `nbf_i` mid-packet have no effect.

## Timing
- Reset values: `tx_o`=1, `nbf_ready_and_o`=1, `busy_o`=0, state `e_idle`, all counters 0.
- Reset mid-packet: on the cycle after `reset_i` is sampled high, outputs take their reset values and the partial packet is discarded. No completion of the in-flight frame.
- Handshake in cycle T: `tx_o` goes low (start bit) in cycle T+1.
- Every bit, including stop and parity, is held exactly `uart_clk_per_bit_p` cycles.
- Frame length F = (1 + 8 + parity + stop) × `uart_clk_per_bit_p` cycles.
- Consecutive bytes of one packet are back-to-back: the next start bit follows the last stop-bit cycle with no idle cycle.
- Packet timing:
  - `tx_o` is low/data from T+1 through T+`nbf_bytes_lp`×F.
  - `nbf_ready_and_o` rises at T+`nbf_bytes_lp`×F+1 (no gap macro).
- Back-to-back packets: with `nbf_v_i` held high, the next handshake occurs in the first ready cycle. The line is therefore idle-high for exactly one cycle between packets.

## Configuration
- `BP_NBF_UART_TX_GAP_EN` defined: after each packet's final stop bit, the block enters `e_gap`.
  - `e_gap` holds `tx_o`=1 and ready low for 10 × `uart_clk_per_bit_p` cycles, then returns to `e_idle`. This gives the host receiver resync margin.
  - Ready rises at T+`nbf_bytes_lp`×F+10×`uart_clk_per_bit_p`+1.
- Macro undefined: `e_gap` and its counter logic are not compiled, and the timing above applies.

## Test plan
Bench configuration: `uart_clk_per_bit_p`=4, address width 32, data width 32, so 9 bytes per packet. F=40 cycles with 1 stop bit and no parity.
- **Reset:** assert `reset_i` for 3 cycles → `tx_o`=1, ready=1, busy=0 throughout and on release.
- **Single packet:** opcode 0x02, addr 0x0000_1000, data 0xDEAD_BEEF, handshake at T.
  - Decoded line bytes: 02 00 10 00 00 EF BE AD DE.
  - `tx_o` low at T+1; ready=1 at T+361.
- **Parity:** byte 0x07.
  - Even parity → parity bit 1.
  - Odd parity → parity bit 0.
  - With `uart_stop_bits_p`=2, F=48 and the stop level is held 8 cycles.
- **Back-to-back:** two packets queued with `nbf_v_i` held high.
  - Second handshake at T+361.
  - `tx_o` high for exactly 1 cycle between the packets.
  - Both packets decode correctly.
- **Mid-packet reset:** reset pulse at T+50 (byte 1, data phase).
  - T+51: `tx_o`=1, ready=1.
  - A new packet then sends cleanly from opcode byte.
- **Gap macro:** with `BP_NBF_UART_TX_GAP_EN` defined and a single packet, ready rises at T+401 and `tx_o` is high for cycles T+361 through T+400.
